// File: rtl/arithmetic_unit_seq.sv
// Multi-cycle arithmetic unit: single-cycle ADD/SUB/SLT/SLTU with a registered result,
// plus iterative shift-add multiply and restoring divide/remainder.
module arithmetic_unit_seq #(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b0110;
   localparam logic [3:0] OP_REMU = 4'b0111;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q, op_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 ovf_q, ovf_d;
   logic                 dbz_q, dbz_d;

   logic                 is_mul_op, is_div_op;
   logic [WIDTH-1:0]     add_sum;
   logic [WIDTH:0]       sub_full;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic [WIDTH-1:0]     imm_result;
   logic                 imm_ovf;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_sh;
   logic                 no_borrow;
   logic [WIDTH-1:0]     rem_diff;
   logic [2*WIDTH-1:0]   div_next;

   assign is_mul_op = (op[3:1] == 3'b010);
   assign is_div_op = (op[3:1] == 3'b011);
   assign a_s       = a;
   assign b_s       = b;

   // Single-cycle results; the DIVU/REMU entries are only used for a zero divisor.
   always_comb begin
      add_sum    = a + b;
      sub_full   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      imm_result = '0;
      imm_ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            imm_result = add_sum;
            imm_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            imm_result = sub_full[WIDTH-1:0];
            imm_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  imm_result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_SLTU: imm_result = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
         OP_DIVU: imm_result = '1;
         OP_REMU: imm_result = a;
         default: ;
      endcase
   end

   // One iteration step: acc holds {hi, multiplier} for MUL and {rem, quot} for DIV.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
      no_borrow = (rem_sh >= {1'b0, opnd_q});
      rem_diff  = rem_sh[WIDTH-1:0] - opnd_q;
      div_next  = no_borrow ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      dbz_d    = dbz_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               ovf_d = 1'b0;
               dbz_d = 1'b0;
               if (is_mul_op || (is_div_op && (b != '0))) begin
                  op_d    = op;
                  opnd_d  = is_mul_op ? a : b;
                  acc_d   = {{WIDTH{1'b0}}, (is_mul_op ? b : a)};
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  result_d = imm_result;
                  ovf_d    = imm_ovf;
                  dbz_d    = is_div_op;
                  state_d  = S_DONE;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = op_q[1] ? div_next : mul_next;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = S_DONE;
               result_d = op_q[0] ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign result      = result_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_arithmetic_unit_seq.sv
// Randomized bench for arithmetic_unit_seq at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_arithmetic_unit_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        sel8;

   logic        busy32, done32, ovf32, dbz32;
   logic [31:0] res32;
   logic        busy8, done8, ovf8, dbz8;
   logic [7:0]  res8;

   logic        busy_o, done_o, ovf_o, dbz_o;
   logic [31:0] res_o;

   int checks = 0;
   int errors = 0;

   logic [3:0] op_tab [10] = '{4'h0, 4'h2, 4'hA, 4'hB, 4'h4, 4'h5, 4'h6, 4'h7, 4'h1, 4'hF};

   always #5 clk = ~clk;

   arithmetic_unit_seq u32 (
      .clk(clk), .reset(reset), .start(start & ~sel8), .op(op_i), .a(a_i), .b(b_i),
      .busy(busy32), .done(done32), .result(res32), .overflow(ovf32), .div_by_zero(dbz32)
   );

   arithmetic_unit_seq #(.WIDTH(8)) u8 (
      .clk(clk), .reset(reset), .start(start & sel8), .op(op_i), .a(a_i[7:0]), .b(b_i[7:0]),
      .busy(busy8), .done(done8), .result(res8), .overflow(ovf8), .div_by_zero(dbz8)
   );

   always_comb begin
      busy_o = sel8 ? busy8 : busy32;
      done_o = sel8 ? done8 : done32;
      ovf_o  = sel8 ? ovf8  : ovf32;
      dbz_o  = sel8 ? dbz8  : dbz32;
      res_o  = sel8 ? {24'h0, res8} : res32;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit values.
   function automatic void model(input int w, input logic [3:0] op, input logic [31:0] xi, yi,
                                 output longint unsigned r, output bit ov, output bit dz,
                                 output int lat);
      longint unsigned mask, x, y, p;
      longint sx, sy, s, hi, lo;
      mask = (64'd1 << w) - 1;
      x = {32'h0, xi} & mask;
      y = {32'h0, yi} & mask;
      sx = x[w-1] ? longint'(x) - longint'(mask) - 1 : longint'(x);
      sy = y[w-1] ? longint'(y) - longint'(mask) - 1 : longint'(y);
      hi = longint'(mask >> 1);
      lo = -hi - 1;
      r = 0; ov = 0; dz = 0; lat = 1;
      case (op)
         4'h0: begin s = sx + sy; r = $unsigned(s) & mask; ov = (s > hi) || (s < lo); end
         4'h2: begin s = sx - sy; r = $unsigned(s) & mask; ov = (s > hi) || (s < lo); end
         4'hA: r = (sx < sy) ? 1 : 0;
         4'hB: r = (x < y) ? 1 : 0;
         4'h4, 4'h5: begin
            p = x * y;
            r = (op == 4'h4) ? (p & mask) : ((p >> w) & mask);
            lat = w + 1;
         end
         4'h6, 4'h7: begin
            if (y == 0) begin
               dz = 1;
               r = (op == 4'h6) ? mask : x;
            end else begin
               r = (op == 4'h6) ? x / y : x % y;
               lat = w + 1;
            end
         end
         default: r = 0;
      endcase
   endfunction

   function automatic logic [31:0] pick_val(input int w);
      logic [31:0] m;
      m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      case ($urandom_range(0, 6))
         0: pick_val = 32'h0;
         1: pick_val = 32'h1;
         2: pick_val = m;
         3: pick_val = (m >> 1) + 32'h1;
         4: pick_val = m >> 1;
         default: pick_val = $urandom & m;
      endcase
   endfunction

   // Issue one op and follow it to done; poke>0 pulses an ADD start at that busy cycle.
   task automatic run_op(input logic [3:0] op, input logic [31:0] x, y, input int poke, input bit b2b);
      longint unsigned er;
      bit eo, ez;
      int el, lat, busy_cnt, w;
      w = sel8 ? 8 : 32;
      model(w, op, x, y, er, eo, ez, el);
      @(negedge clk);
      start = 1'b1; op_i = op; a_i = x; b_i = y;
      @(posedge clk); #1;
      lat = 1;
      busy_cnt = 0;
      while (!done_o && lat < 80) begin
         busy_cnt += int'(busy_o);
         if (lat == poke) begin
            start = 1'b1; op_i = 4'h0; a_i = 32'd3; b_i = 32'd4;
         end else begin
            start = 1'b0; op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check($sformatf("latency op%0h", op), lat, el);
      check($sformatf("busy_cycles op%0h", op), busy_cnt, el - 1);
      check($sformatf("result op%0h a=%0h b=%0h", op, x, y), res_o, er);
      check($sformatf("overflow op%0h", op), ovf_o, eo);
      check($sformatf("div_by_zero op%0h", op), dbz_o, ez);
      if (!b2b) begin
         @(posedge clk); #1;
         check("done_one_cycle", done_o, 0);
         check("result_hold", res_o, er);
      end
   endtask

   task automatic random_ops(input int n);
      logic [3:0] op;
      logic [31:0] x, y;
      int w;
      w = sel8 ? 8 : 32;
      for (int i = 0; i < n; i++) begin
         op = op_tab[$urandom_range(0, 9)];
         x = pick_val(w);
         y = pick_val(w);
         if ((op == 4'h4 || op == 4'h5) && y == 0) y = 32'h1;
         run_op(op, x, y, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0,
                $urandom_range(0, 3) == 0);
      end
   endtask

   initial begin
      int dn;
      reset = 1'b1; start = 1'b0; sel8 = 1'b0; op_i = 4'h0; a_i = '0; b_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", busy_o, 0);
      check("reset_done", done_o, 0);
      check("reset_result", res_o, 0);
      check("reset_ovf", ovf_o, 0);
      check("reset_dbz", dbz_o, 0);
      @(negedge clk);
      reset = 1'b0;

      run_op(4'h0, 32'h7FFF_FFFF, 32'h1, 0, 0);
      check("add_ovf_value", res_o, 32'h8000_0000);
      check("add_ovf_flag", ovf_o, 1);
      run_op(4'h2, 32'd5, 32'd7, 0, 0);
      check("sub_value", res_o, 32'hFFFF_FFFE);
      check("sub_flag", ovf_o, 0);
      run_op(4'hA, 32'hFFFF_FFFF, 32'h1, 0, 0);
      check("slt_value", res_o, 32'h1);
      run_op(4'hB, 32'hFFFF_FFFF, 32'h1, 0, 0);
      check("sltu_value", res_o, 32'h0);
      run_op(4'h4, 32'h0001_0000, 32'h0001_0003, 0, 0);
      check("mul_value", res_o, 32'h0003_0000);
      run_op(4'h5, 32'h0001_0000, 32'h0001_0003, 0, 0);
      check("mulhu_value", res_o, 32'h1);
      run_op(4'h6, 32'd100, 32'd7, 0, 0);
      check("divu_value", res_o, 32'd14);
      run_op(4'h7, 32'd100, 32'd7, 0, 0);
      check("remu_value", res_o, 32'd2);
      run_op(4'h6, 32'd9, 32'd0, 0, 0);
      check("div0_value", res_o, 32'hFFFF_FFFF);
      check("div0_flag", dbz_o, 1);
      run_op(4'h6, 32'd100, 32'd7, 5, 0);
      check("ignored_start_value", res_o, 32'd14);
      run_op(4'h6, 32'd1000, 32'd10, 0, 1);
      run_op(4'h0, 32'd3, 32'd4, 0, 0);
      check("b2b_add_value", res_o, 32'd7);
      run_op(4'hF, 32'h1234, 32'h5678, 0, 0);
      check("illegal_value", res_o, 32'h0);

      @(negedge clk);
      start = 1'b1; op_i = 4'h4; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_busy", busy_o, 0);
      check("abort_done", done_o, 0);
      check("abort_result", res_o, 0);
      @(negedge clk);
      reset = 1'b0;
      dn = 0;
      repeat (40) begin
         @(posedge clk); #1;
         dn += int'(done_o);
      end
      check("abort_no_done", dn, 0);

      random_ops(150);

      repeat (3) @(posedge clk);
      sel8 = 1'b1;
      run_op(4'h4, 32'h0F, 32'h11, 0, 0);
      check("mul8_value", res_o, 32'hFF);
      random_ops(120);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
